// File: rtl/async_fifo_rd_ctrl.sv
// Read-side controller for the asynchronous FIFO: read pointers, write-pointer
// synchronizer, registered empty/level/underflow and show-ahead data path.
module async_fifo_rd_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int DEPTH       = 16,
    parameter int SYNC_STAGES = 2,
    localparam int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  r_clk,
    input  logic                  r_rst,
    input  logic [ADDR_W:0]       wptr_gray,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] mem_r_data,
    output logic [ADDR_W-1:0]     r_addr,
    output logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_empty,
    output logic                  r_underflow,
    output logic [ADDR_W:0]       r_level,
    output logic [ADDR_W:0]       rptr_gray
);

    logic [ADDR_W:0] sync_q [SYNC_STAGES];
    logic [ADDR_W:0] wq_gray;
    logic [ADDR_W:0] wq_bin;
    logic [ADDR_W:0] rbin;
    logic [ADDR_W:0] rbin_next;
    logic [ADDR_W:0] rgray_next;
    logic            pop;

    // Write pointer crosses domains as Gray, so only one bit changes per step
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wptr_gray;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wq_gray = sync_q[SYNC_STAGES-1];

    always_comb begin
        wq_bin         = '0;
        wq_bin[ADDR_W] = wq_gray[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) begin
            wq_bin[i] = wq_bin[i+1] ^ wq_gray[i];
        end
    end

    assign pop        = r_en & ~r_empty;
    assign rbin_next  = rbin + {{ADDR_W{1'b0}}, pop};
    assign rgray_next = rbin_next ^ (rbin_next >> 1);

    // Flags are computed from the post-pop pointer so the last pop raises empty with no bubble
    always_ff @(posedge r_clk or posedge r_rst) begin
        if (r_rst) begin
            rbin        <= '0;
            rptr_gray   <= '0;
            r_empty     <= 1'b1;
            r_underflow <= 1'b0;
            r_level     <= '0;
        end else begin
            rbin        <= rbin_next;
            rptr_gray   <= rgray_next;
            r_empty     <= (rgray_next == wq_gray);
            r_underflow <= r_en & r_empty;
            r_level     <= wq_bin - rbin_next;
        end
    end

    assign r_addr = rbin[ADDR_W-1:0];
    assign r_data = mem_r_data;

endmodule

// File: tb/tb_async_fifo_rd_ctrl.sv
// Randomized bench for async_fifo_rd_ctrl against a counting model of the FIFO
// (total writes, total pops, and a delayed view of the write count).
module tb_async_fifo_rd_ctrl;

    localparam int DATA_WIDTH  = 8;
    localparam int DEPTH       = 16;
    localparam int SYNC_STAGES = 2;
    localparam int ADDR_W      = $clog2(DEPTH);

    logic                  r_clk = 1'b0;
    logic                  r_rst = 1'b1;
    logic [ADDR_W:0]       wptr_gray = '0;
    logic                  r_en = 1'b0;
    logic [DATA_WIDTH-1:0] mem_r_data;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_empty;
    logic                  r_underflow;
    logic [ADDR_W:0]       r_level;
    logic [ADDR_W:0]       rptr_gray;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    int total = 0;
    int bad   = 0;

    // Reference model: counts are plain integers, never wrapped
    int                    wcount;
    int                    rcount;
    int                    seen_q[$];
    logic [DATA_WIDTH-1:0] data_log [int];
    bit                    m_empty;
    bit                    m_under;
    int                    m_level;
    bit                    seq_mode;

    async_fifo_rd_ctrl #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .SYNC_STAGES(SYNC_STAGES)
    ) dut (
        .r_clk      (r_clk),
        .r_rst      (r_rst),
        .wptr_gray  (wptr_gray),
        .r_en       (r_en),
        .mem_r_data (mem_r_data),
        .r_addr     (r_addr),
        .r_data     (r_data),
        .r_empty    (r_empty),
        .r_underflow(r_underflow),
        .r_level    (r_level),
        .rptr_gray  (rptr_gray)
    );

    always #5 r_clk = ~r_clk;

    assign mem_r_data = mem[r_addr];

    function automatic logic [ADDR_W:0] to_gray(input int n);
        logic [ADDR_W:0] b;
        b = n[ADDR_W:0];
        return b ^ (b >> 1);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic checkAll();
        checkOutput("empty", 32'(r_empty), 32'(m_empty));
        checkOutput("level", 32'(r_level), 32'(m_level));
        checkOutput("underflow", 32'(r_underflow), 32'(m_under));
        checkOutput("r_addr", 32'(r_addr), 32'(rcount % DEPTH));
        checkOutput("rptr_gray", 32'(rptr_gray), 32'(to_gray(rcount)));
        if (!m_empty) begin
            checkOutput("r_data", 32'(r_data), 32'(data_log[rcount]));
        end
    endtask

    task automatic modelReset();
        wcount  = 0;
        rcount  = 0;
        seen_q  = {};
        for (int i = 0; i < SYNC_STAGES; i++) seen_q.push_back(0);
        data_log.delete();
        m_empty = 1'b1;
        m_under = 1'b0;
        m_level = 0;
    endtask

    // Called at a negedge: drive inputs, let one rising edge happen, check at the next negedge
    task automatic applyStimulus(input bit en, input int nwr);
        int seen;
        for (int i = 0; i < nwr; i++) begin
            if (wcount - rcount < DEPTH) begin
                data_log[wcount] = seq_mode ? DATA_WIDTH'(wcount) : DATA_WIDTH'($urandom);
                mem[wcount % DEPTH] = data_log[wcount];
                wcount++;
            end
        end
        wptr_gray = to_gray(wcount);
        r_en      = en;
        @(posedge r_clk);
        m_under = en && m_empty;
        if (en && !m_empty) rcount++;
        seen = seen_q.pop_front();
        seen_q.push_back(wcount);
        m_empty = (seen == rcount);
        m_level = seen - rcount;
        @(negedge r_clk);
        checkAll();
    endtask

    // Reset is asserted between edges to prove it acts without a clock
    task automatic midCycleReset();
        #2;
        r_rst     = 1'b1;
        r_en      = 1'b0;
        wptr_gray = '0;
        #1;
        modelReset();
        checkOutput("rst_empty", 32'(r_empty), 32'd1);
        checkOutput("rst_addr", 32'(r_addr), 32'd0);
        checkOutput("rst_rgray", 32'(rptr_gray), 32'd0);
        checkOutput("rst_level", 32'(r_level), 32'd0);
        checkOutput("rst_under", 32'(r_underflow), 32'd0);
        @(negedge r_clk);
        @(negedge r_clk);
        r_rst = 1'b0;
    endtask

    initial begin
        int wrote;
        int wraps;
        int cycles;
        logic [ADDR_W-1:0] prev_addr;

        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        modelReset();
        seq_mode = 1'b0;
        @(negedge r_clk);
        @(negedge r_clk);
        checkAll();
        r_rst = 1'b0;

        // Single write: empty must fall on the third edge with level 1
        applyStimulus(1'b0, 1);
        checkOutput("single_e1", 32'(r_empty), 32'd1);
        applyStimulus(1'b0, 0);
        checkOutput("single_e2", 32'(r_empty), 32'd1);
        applyStimulus(1'b0, 0);
        checkOutput("single_e3", 32'(r_empty), 32'd0);
        checkOutput("single_lvl", 32'(r_level), 32'd1);
        applyStimulus(1'b1, 0);
        checkOutput("single_pop_e", 32'(r_empty), 32'd1);
        checkOutput("single_rgray", 32'(rptr_gray), 32'd1);

        // Full drain of words 0..15
        midCycleReset();
        seq_mode = 1'b1;
        applyStimulus(1'b0, DEPTH);
        checkOutput("full_wgray", 32'(wptr_gray), 32'h18);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0);
        checkOutput("full_lvl", 32'(r_level), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            checkOutput("drain_data", 32'(r_data), 32'(i));
            applyStimulus(1'b1, 0);
            checkOutput("drain_lvl", 32'(r_level), 32'(DEPTH - 1 - i));
        end
        checkOutput("drain_empty", 32'(r_empty), 32'd1);
        checkOutput("drain_rgray", 32'(rptr_gray), 32'h18);

        // Underflow: three pops while empty
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 0);
            checkOutput("uf_pulse", 32'(r_underflow), 32'd1);
        end
        checkOutput("uf_addr", 32'(r_addr), 32'd0);
        applyStimulus(1'b0, 0);

        // Wrap-around: 40 words, random interleave
        midCycleReset();
        seq_mode  = 1'b0;
        wrote     = 0;
        wraps     = 0;
        cycles    = 0;
        prev_addr = r_addr;
        while (rcount < 40 && cycles < 2000) begin
            int nw;
            nw = (wrote < 40 && $urandom_range(0, 3) != 0) ? 1 : 0;
            if (wcount - rcount >= DEPTH) nw = 0;
            wrote += nw;
            applyStimulus($urandom_range(0, 3) != 0, nw);
            if (prev_addr == ADDR_W'(DEPTH - 1) && r_addr == '0) wraps++;
            prev_addr = r_addr;
            cycles++;
        end
        checkOutput("wrap_done", 32'(rcount), 32'd40);
        checkOutput("wrap_count", 32'(wraps), 32'd2);

        // Reset mid-drain
        midCycleReset();
        applyStimulus(1'b0, 10);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b1, 0);
        midCycleReset();
        applyStimulus(1'b0, 1);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 0);
        checkOutput("post_rst_addr", 32'(r_addr), 32'd0);
        checkOutput("post_rst_data", 32'(r_data), 32'(data_log[0]));

        // Free-running random traffic
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0 ? 0 : 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
